// File: rtl/chksum_pkt_ctrl.sv
// ----------------------------------------------------------------------------
// chksum_pkt_ctrl
//
// Runs a 16-bit one's-complement checksum over framed packets arriving on a
// 64-bit valid/ready stream. Every beat has its bytes masked by s_keep and its
// carries folded back into the sum, so the accumulator is always a complete
// 16-bit partial sum. When the last beat arrives the sum, the match flag and
// the byte count are registered and offered on a valid/ready result port.
//
// Optional feature (compile-time macro CHKSUM_SEED_EN):
//   defined     : adds input s_seed[15:0]. It is sampled on the first beat
//                 of a packet (a transfer in IDLE) and used as the initial
//                 accumulator, e.g. a pseudo-header partial sum.
//   not defined : no s_seed port, the accumulator starts from 0.
//
// Parameters:
//   INVERT  1: m_chksum = ~sum, 0: m_chksum = sum
//   LEN_W   width of the byte counter m_len (saturates at all-ones)
//
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   s_valid     input beat valid
//   s_ready     block can accept a beat (IDLE/ACCUM and not in reset)
//   s_data      beat data, 16-bit lanes [15:0],[31:16],[47:32],[63:48]
//   s_keep      byte enables, s_keep[i] qualifies s_data[8i+7:8i]
//   s_last      final beat of the packet
//   s_seed      initial sum (only with CHKSUM_SEED_EN)
//   m_valid     result valid
//   m_ready     result consumed
//   m_chksum    checksum
//   m_match     folded sum == 16'hFFFF before inversion
//   m_len       accepted byte count
//   busy        state != IDLE
//   dbg_state   current FSM state (IDLE=0, ACCUM=1, FOLD=2, HOLD=3)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, stays high with stable payload until
// that transfer, and ready may be raised or lowered at any time.
// ----------------------------------------------------------------------------
module chksum_pkt_ctrl #(
    parameter bit INVERT = 1'b1,
    parameter int LEN_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [63:0]      s_data,
    input  logic [7:0]       s_keep,
    input  logic             s_last,
`ifdef CHKSUM_SEED_EN
    input  logic [15:0]      s_seed,
`endif
    output logic             m_valid,
    input  logic             m_ready,
    output logic [15:0]      m_chksum,
    output logic             m_match,
    output logic [LEN_W-1:0] m_len,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FOLD  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]      acc;
    logic [LEN_W-1:0] len;
    logic [15:0]      seed_val;

    logic             xfer;
    logic             res_done;
    logic [63:0]      masked;
    logic [15:0]      acc_base;
    logic [18:0]      t_sum;
    logic [16:0]      f_sum;
    logic [15:0]      acc_sum;
    logic [3:0]       pop;
    logic [LEN_W-1:0] len_base;
    logic [LEN_W:0]   len_sum;
    logic [LEN_W-1:0] len_sat;

`ifdef CHKSUM_SEED_EN
    assign seed_val = s_seed;
`else
    assign seed_val = 16'h0000;
`endif

    assign xfer     = s_valid & s_ready;
    assign res_done = (state == HOLD) & m_valid & m_ready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_next = s_last ? FOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (xfer && s_last) begin
                    state_next = FOLD;
                end
            end
            FOLD: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (res_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // s_ready is gated by reset directly so nothing is taken in the reset cycle.
    always_comb begin
        s_ready   = ~reset & ((state == IDLE) | (state == ACCUM));
        busy      = (state != IDLE);
        dbg_state = state;
    end

    // ---------------------------------------------------------- datapath
    // Bytes with keep=0 are forced to zero before the lane sum.
    always_comb begin
        masked = '0;
        for (int i = 0; i < 8; i++) begin
            masked[8*i +: 8] = s_keep[i] ? s_data[8*i +: 8] : 8'h00;
        end
    end

    // The first beat of a packet starts from the seed (or zero) rather than
    // whatever the accumulator last held.
    assign acc_base = (state == IDLE) ? seed_val : acc;

    // Four lanes plus the accumulator fit in 19 bits. After the first fold
    // f_sum <= 0x10003, so when f_sum[16] is set the low half is at most 3
    // and the second fold cannot carry again.
    assign t_sum   = {3'b000, acc_base}
                   + {3'b000, masked[15:0]}
                   + {3'b000, masked[31:16]}
                   + {3'b000, masked[47:32]}
                   + {3'b000, masked[63:48]};
    assign f_sum   = {1'b0, t_sum[15:0]} + {14'b0, t_sum[18:16]};
    assign acc_sum = f_sum[15:0] + {15'b0, f_sum[16]};

    always_comb begin
        pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + {3'b000, s_keep[i]};
        end
    end

    assign len_base = (state == IDLE) ? '0 : len;
    assign len_sum  = {1'b0, len_base} + {{(LEN_W-3){1'b0}}, pop};
    assign len_sat  = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= 16'h0000;
            len <= '0;
        end else if (xfer) begin
            acc <= acc_sum;
            len <= len_sat;
        end else if (res_done) begin
            acc <= 16'h0000;
            len <= '0;
        end
    end

    // ------------------------------------------------------- result port
    // Result fields are captured in FOLD and then held, including after the
    // result is consumed, until the next packet reaches FOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_chksum <= 16'h0000;
            m_match  <= 1'b0;
            m_len    <= '0;
        end else if (state == FOLD) begin
            m_chksum <= INVERT ? ~acc : acc;
            m_match  <= (acc == 16'hFFFF);
            m_len    <= len;
        end
    end

    // m_valid is raised one cycle after entering HOLD, so a last beat taken
    // at edge N gives m_valid high after edge N+2. It drops on the edge that
    // completes the result handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
        end else if (state == HOLD) begin
            if (!m_valid) begin
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end else begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chksum_pkt_ctrl.sv
// ----------------------------------------------------------------------------
// tb_chksum_pkt_ctrl
//
// Directed bench for chksum_pkt_ctrl. The stimulus process pushes the
// hand-computed result {chksum, match, len} into exp_q before sending each
// packet; a monitor on the falling edge pops and compares whenever a result
// handshake is about to happen, checks result latency and checks that held
// results stay stable under backpressure.
// ----------------------------------------------------------------------------
module tb_chksum_pkt_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] s_data = 64'h0;
    logic [7:0]  s_keep = 8'h0;
    logic        s_last = 1'b0;
`ifdef CHKSUM_SEED_EN
    logic [15:0] s_seed = 16'h0000;
`endif
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_chksum;
    logic        m_match;
    logic [15:0] m_len;
    logic        busy;
    logic [1:0]  dbg_state;

    chksum_pkt_ctrl #(
        .INVERT (1'b1),
        .LEN_W  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_keep    (s_keep),
        .s_last    (s_last),
`ifdef CHKSUM_SEED_EN
        .s_seed    (s_seed),
`endif
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_chksum  (m_chksum),
        .m_match   (m_match),
        .m_len     (m_len),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------ clock / reset block
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------- scoreboard
    logic [32:0] exp_q[$];   // {chksum[15:0], match, len[15:0]}
    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_accept = -100;
    int          release_cyc = 0;
    logic        prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [15:0] chk, input logic match, input logic [15:0] len);
        exp_q.push_back({chk, match, len});
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (!reset) begin
            if (m_valid === 1'b1 && prev_valid !== 1'b1) begin
                check("result_expected", 64'(exp_q.size() != 0), 64'd1);
                check("latency", 64'(cyc - last_accept), 64'd2);
            end
            if (m_valid === 1'b1 && exp_q.size() != 0) begin
                e = exp_q[0];
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    check("m_chksum", 64'(m_chksum), 64'(e[32:17]));
                    check("m_match", 64'(m_match), 64'(e[16]));
                    check("m_len", 64'(m_len), 64'(e[15:0]));
                end else begin
                    check("hold_chksum", 64'(m_chksum), 64'(e[32:17]));
                    check("hold_len", 64'(m_len), 64'(e[15:0]));
                    check("hold_s_ready", 64'(s_ready), 64'd0);
                end
            end
        end
        prev_valid <= m_valid;
    end

    // ---------------------------------------------------- driver tasks
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic last);
        int budget = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = last;
        while (s_ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) begin
            check("s_ready_timeout", 64'd0, 64'd1);
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            last_accept = cyc;
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_valid();
        int budget = 0;
        while (m_valid !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("valid_timeout", 64'(m_valid), 64'd1);
    endtask

    // -------------------------------------------------------- stimulus
    initial begin
        repeat (2) @(negedge clk);
        check("reset_s_ready_low", 64'(s_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_chksum", 64'(m_chksum), 64'd0);
        check("rst_m_match", 64'(m_match), 64'd0);
        check("rst_m_len", 64'(m_len), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // single beat, plain sum
        push_exp(16'hFFF5, 1'b0, 16'd8);
        send_beat(64'h0001_0002_0003_0004, 8'hFF, 1'b1);
        wait_drain();

        // double carry fold
        push_exp(16'hFFFE, 1'b0, 16'd8);
        send_beat(64'hFFFF_FFFF_0000_0001, 8'hFF, 1'b1);
        wait_drain();

        // only the low lane kept
        push_exp(16'hBBBB, 1'b0, 16'd2);
        send_beat(64'h1111_2222_3333_4444, 8'h03, 1'b1);
        wait_drain();

        // two beats summing to FFFF
        push_exp(16'h0000, 1'b1, 16'd16);
        send_beat(64'h0000_0000_0000_1234, 8'hFF, 1'b0);
        send_beat(64'h0000_0000_0000_EDCB, 8'hFF, 1'b1);
        wait_drain();

        // keep=0 beat in the middle, single byte on the last beat
        push_exp(16'hFFE5, 1'b0, 16'd9);
        send_beat(64'h0001_0002_0003_0004, 8'hFF, 1'b0);
        send_beat(64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 1'b0);
        send_beat(64'h0000_0000_0000_0010, 8'h01, 1'b1);
        wait_drain();

        // scattered byte mask A5: lanes 0022,00FF,CC00,AA00 -> 7722
        push_exp(16'h88DD, 1'b0, 16'd4);
        send_beat(64'hAABB_CCDD_EEFF_1122, 8'hA5, 1'b1);
        wait_drain();

        // all-ones beats carry every time
        push_exp(16'h0000, 1'b1, 16'd24);
        repeat (2) send_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        wait_drain();

        // result backpressure with the next packet waiting
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        push_exp(16'hFFF5, 1'b0, 16'd8);
        send_beat(64'h0001_0002_0003_0004, 8'hFF, 1'b1);
        push_exp(16'hBBBB, 1'b0, 16'd2);
        wait_valid();
        fork
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_s_ready", 64'(s_ready), 64'd0);
                    check("bp_m_valid", 64'(m_valid), 64'd1);
                end
                @(posedge clk);
                #1;
                m_ready = 1'b1;
                release_cyc = cyc;
            end
            begin
                send_beat(64'h1111_2222_3333_4444, 8'h03, 1'b1);
            end
        join
        check("bp_accept_cycle", 64'(last_accept), 64'(release_cyc + 2));
        wait_drain();

        // reset in the middle of a packet: nothing emitted
        send_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
        send_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_s_ready", 64'(s_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_m_chksum", 64'(m_chksum), 64'd0);
        check("midrst_m_len", 64'(m_len), 64'd0);
        repeat (4) @(negedge clk);
        check("midrst_no_valid", 64'(m_valid), 64'd0);
`ifdef CHKSUM_SEED_EN
        s_seed = 16'h0005;
        push_exp(16'hFFF0, 1'b0, 16'd8);
`else
        push_exp(16'hFFF5, 1'b0, 16'd8);
`endif
        send_beat(64'h0001_0002_0003_0004, 8'hFF, 1'b1);
        wait_drain();
`ifdef CHKSUM_SEED_EN
        s_seed = 16'h0000;
`endif

        // byte counter saturates: 8193 full beats of zero data
        push_exp(16'hFFFF, 1'b0, 16'hFFFF);
        for (int i = 0; i < 8192; i++) begin
            send_beat(64'h0, 8'hFF, 1'b0);
        end
        send_beat(64'h0, 8'hFF, 1'b1);
        wait_drain();

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
